cache_mem_arbiter: RTL and testbench

Shares the single backing-memory port between the instruction cache and the data cache. Each cache issues whole-line transactions: I-cache refills, D-cache refills, and D-cache writebacks. The arbiter grants one requester at a time using round-robin priority, then sequences the line as a burst of word beats on the memory port. It sits between the two cache FSMs and main memory and replaces direct cache-to-memory wiring.

---
 rtl/cache_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//
// Shares one backing-memory port between the I-cache and the D-cache.
// Each cache asks for a whole line: an I-cache refill, a D-cache refill or a
// D-cache writeback. One requester is granted at a time, with round-robin
// priority on a tie. The line then runs as a burst of WORDS_PER_LINE word
// beats on the memory port.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   ic_req/ic_addr         I-cache refill request and line address
//   ic_rdata/ic_rvalid     I-cache refill beat data and qualifier
//   ic_done                one-cycle pulse at the end of an I-cache line
//   dc_req/dc_we/dc_addr   D-cache request, direction (1 = writeback), line address
//   dc_wdata/dc_wready     writeback word for beat_idx and its accept strobe
//   dc_rdata/dc_rvalid     D-cache refill beat data and qualifier
//   dc_done                one-cycle pulse at the end of a D-cache line
//   beat_idx               word index of the current beat within the line
//   busy                   high while a transaction is in flight (BURST or DONE)
//   mem_valid/mem_we       memory beat request and direction
//   mem_addr/mem_wdata     beat byte address and write data
//   mem_ready/mem_rdata    beat completion and read data from memory
module cache_mem_arbiter #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ic_req,
  input  logic [ADDR_W-1:0]                 ic_addr,
  output logic [DATA_W-1:0]                 ic_rdata,
  output logic                              ic_rvalid,
  output logic                              ic_done,
  input  logic                              dc_req,
  input  logic                              dc_we,
  input  logic [ADDR_W-1:0]                 dc_addr,
  input  logic [DATA_W-1:0]                 dc_wdata,
  output logic                              dc_wready,
  output logic [DATA_W-1:0]                 dc_rdata,
  output logic                              dc_rvalid,
  output logic                              dc_done,
  output logic [$clog2(WORDS_PER_LINE)-1:0] beat_idx,
  output logic                              busy,
  output logic                              mem_valid,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic                              mem_ready,
  input  logic [DATA_W-1:0]                 mem_rdata
);

  localparam int BEAT_W  = $clog2(WORDS_PER_LINE);
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int OFF_W   = BEAT_W + BYTE_SH;

  // Clears the line-offset bits; applied to the full address so every bit is used.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q;
  logic                owner_dc_q;  // 1 = D-cache owns the current transaction
  logic                we_q;        // latched direction of the current transaction
  logic                last_dc_q;   // 1 = last grant went to the D-cache
  logic [ADDR_W-1:0]   base_q;
  logic [BEAT_W-1:0]   beat_q;

  logic                grant_dc_d;
  logic [ADDR_W-1:0]   base_d;

  // Round-robin: on a tie the requester that was not granted last wins.
  always_comb begin
    grant_dc_d = dc_req & (~ic_req | ~last_dc_q);
    base_d     = (grant_dc_d ? dc_addr : ic_addr) & LINE_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_dc_q <= 1'b0;
      we_q       <= 1'b0;
      last_dc_q  <= 1'b0;
      base_q     <= '0;
      beat_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ic_req | dc_req) begin
            owner_dc_q <= grant_dc_d;
            we_q       <= grant_dc_d & dc_we;
            base_q     <= base_d;
            beat_q     <= '0;
            state_q    <= S_BURST;
          end
        end
        S_BURST: begin
          // Everything holds while memory stalls the beat.
          if (mem_ready) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Requests are ignored here; the owner drops its req after seeing done.
          last_dc_q <= owner_dc_q;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          beat_q  <= '0;
        end
      endcase
    end
  end

  logic in_burst;
  logic in_done;
  logic beat_fire;

  always_comb begin
    in_burst  = (state_q == S_BURST);
    in_done   = (state_q == S_DONE);
    beat_fire = in_burst & mem_ready;

    busy      = in_burst | in_done;
    beat_idx  = beat_q;

    mem_valid = in_burst;
    mem_we    = in_burst & we_q;
    // The base has its offset bits cleared, so the add never carries out of the line.
    mem_addr  = in_burst ? (base_q + (ADDR_W'(beat_q) << BYTE_SH)) : '0;
    mem_wdata = dc_wdata;

    ic_rdata  = mem_rdata;
    dc_rdata  = mem_rdata;
    ic_rvalid = beat_fire & ~owner_dc_q;
    dc_rvalid = beat_fire & owner_dc_q & ~we_q;
    dc_wready = beat_fire & owner_dc_q & we_q;

    ic_done   = in_done & ~owner_dc_q;
    dc_done   = in_done & owner_dc_q;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios followed by randomized
// transactions, each checked cycle by cycle against a transaction-level model
// (round-robin owner, line base by modulo arithmetic, beat address by
// multiplication).
module tb_cache_mem_arbiter;

  localparam int WPL  = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = $clog2(WPL);
  localparam logic [AW-1:0] LINE_BYTES = AW'(WPL * DW / 8);

  logic          clk;
  logic          rst;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic [DW-1:0] ic_rdata;
  logic          ic_rvalid;
  logic          ic_done;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic          dc_wready;
  logic [DW-1:0] dc_rdata;
  logic          dc_rvalid;
  logic          dc_done;
  logic [BW-1:0] beat_idx;
  logic          busy;
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  cache_mem_arbiter #(
    .WORDS_PER_LINE(WPL),
    .ADDR_W        (AW),
    .DATA_W        (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_rdata (ic_rdata),
    .ic_rvalid(ic_rvalid),
    .ic_done  (ic_done),
    .dc_req   (dc_req),
    .dc_we    (dc_we),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_wready(dc_wready),
    .dc_rdata (dc_rdata),
    .dc_rvalid(dc_rvalid),
    .dc_done  (dc_done),
    .beat_idx (beat_idx),
    .busy     (busy),
    .mem_valid(mem_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit lg_ic  = 1'b1;  // model: last grant was the I-cache

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_we"},    mem_we, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_beat_idx"},  beat_idx, 0);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_pulses"},    {ic_rvalid, dc_rvalid, dc_wready, ic_done, dc_done}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    lg_ic = 1'b1;
  endtask

  // Called in an IDLE cycle with requests already driven; returns in the
  // IDLE cycle after DONE, with the owner's request dropped.
  task automatic txn(input int stall_beat, input int stall_len, input bit rnd_stall);
    bit            odc, we, rdy;
    logic [AW-1:0] a, base;
    int            beat, left, rv, wr;
    odc  = dc_req && (!ic_req || lg_ic);
    we   = odc && dc_we;
    a    = odc ? dc_addr : ic_addr;
    base = a - (a % LINE_BYTES);
    tick();
    beat = 0; left = stall_len; rv = 0; wr = 0;
    while (beat < WPL) begin
      rdy = 1'b1;
      if (beat == stall_beat && left > 0) begin
        rdy = 1'b0;
        left--;
      end else if (rnd_stall && $urandom_range(0, 3) == 0) begin
        rdy = 1'b0;
      end
      mem_ready = rdy;
      mem_rdata = $urandom;
      dc_wdata  = $urandom;
      @(negedge clk);
      chk("burst_valid", mem_valid, 1);
      chk("burst_busy",  busy, 1);
      chk("burst_we",    mem_we, we);
      chk("burst_addr",  mem_addr, base + AW'(beat * (DW / 8)));
      chk("burst_beat",  beat_idx, beat);
      chk("burst_wdata", mem_wdata, dc_wdata);
      chk("ic_rvalid",   ic_rvalid, rdy && !odc);
      chk("dc_rvalid",   dc_rvalid, rdy && odc && !we);
      chk("dc_wready",   dc_wready, rdy && we);
      chk("burst_done",  {ic_done, dc_done}, 0);
      if (rdy && !we) chk("rdata", odc ? dc_rdata : ic_rdata, mem_rdata);
      rv += int'(ic_rvalid | dc_rvalid);
      wr += int'(dc_wready);
      if (rdy) beat++;
      tick();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rvalid_pulses", rv, we ? 0 : WPL);
    chk("wready_pulses", wr, we ? WPL : 0);
    chk("done_ic",    ic_done, !odc);
    chk("done_dc",    dc_done, odc);
    chk("done_busy",  busy, 1);
    chk("done_valid", mem_valid, 0);
    lg_ic = !odc;
    tick();
    if (odc) dc_req = 1'b0;
    else     ic_req = 1'b0;
    @(negedge clk);
    chk("idle_busy",  busy, 0);
    chk("idle_valid", mem_valid, 0);
    chk("idle_done",  {ic_done, dc_done}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] rbase;
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    do_reset();

    // I-cache refill of the line holding 0x1008
    ic_req = 1'b1; ic_addr = 32'h0000_1008;
    txn(-1, 0, 1'b0);

    // D-cache writeback of 0x2010..0x201C
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_2010;
    txn(-1, 0, 1'b0);

    // Simultaneous requests after reset: D, then I, then D again
    do_reset();
    ic_req = 1'b1; ic_addr = $urandom;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = $urandom;
    txn(-1, 0, 1'b0);
    txn(-1, 0, 1'b0);
    ic_req = 1'b1; ic_addr = $urandom;
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = $urandom;
    txn(-1, 0, 1'b0);
    txn(-1, 0, 1'b0);

    // Read with mem_ready low for 3 cycles on beat 2
    ic_req = 1'b1; ic_addr = 32'h0000_3000;
    txn(2, 3, 1'b0);

    // Reset during beat 1 of a writeback, then the request is reissued
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_4024;
    rbase = 32'h0000_4020;
    tick();
    mem_ready = 1'b1; dc_wdata = $urandom;
    @(negedge clk);
    chk("rst_b0_beat", beat_idx, 0);
    chk("rst_b0_addr", mem_addr, rbase);
    chk("rst_b0_wready", dc_wready, 1);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_b1_beat", beat_idx, 1);
    chk("rst_b1_addr", mem_addr, rbase + 32'd4);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    @(negedge clk);
    check_reset_outputs("midrst2");
    rst = 1'b0;
    lg_ic = 1'b1;
    txn(-1, 0, 1'b0);

    // Line at the top of the address space
    ic_req = 1'b1; ic_addr = 32'hFFFF_FFF4;
    txn(-1, 0, 1'b0);

    // Randomized requests, addresses, directions and stalls
    for (int i = 0; i < 16; i++) begin
      if (!ic_req) begin
        ic_req  = 1'($urandom_range(0, 1));
        ic_addr = $urandom;
      end
      if (!dc_req) begin
        dc_req  = 1'($urandom_range(0, 1));
        dc_we   = 1'($urandom_range(0, 1));
        dc_addr = $urandom;
      end
      if (!ic_req && !dc_req) dc_req = 1'b1;
      txn($urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
